ils_instr_gen: RTL and testbench

Synthesizable constrained-random instruction source for the Sodor 5-stage lifting traces. It produces I-type ALU, load and store words under a valid/ready handshake and feeds the `instr` input of the `sodor5_verif` pair. A 32-bit Galois LFSR drives the field values. Per-class counters and a `done` flag bound each trace run.

---
 rtl/ils_instr_gen.sv | 198 +++++++++++++++++++
 tb/tb_ils_instr_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ils_instr_gen.sv
// ils_instr_gen: constrained-random RV32I instruction source.
// Emits warmup NOPs, then a bounded stream of I-type ALU, load and store words
// derived from a 32-bit Galois LFSR, under a valid/ready handshake.
module ils_instr_gen #(
    parameter logic [31:0] SEED       = 32'd1019,
    parameter logic [15:0] NUM_INSTRS = 16'd100,
    parameter logic [3:0]  WARMUP     = 4'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        busy,
    output logic        done,
    output logic [15:0] cnt_alu,
    output logic [15:0] cnt_ld,
    output logic [15:0] cnt_st
);

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] FEEDBACK  = 32'h80200003;
    localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] lfsr_q;
    logic [31:0] word_q;
    logic        word_valid_q;
    logic [1:0]  class_q;
    logic [3:0]  warm_cnt_q;
    logic [15:0] gen_cnt_q;
    logic [15:0] acc_cnt_q;

    logic        accept;
    logic        load;
    logic        warm_exit;
    logic        clear_cnt;
    logic        count_acc;

    logic [31:0] step_a;
    logic [31:0] step_b;
    logic [31:0] new_word;
    logic [1:0]  choice;
    logic [11:0] imm;
    logic [11:0] imm_l;
    logic [2:0]  funct3;
    logic [2:0]  funct3_l;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ FEEDBACK) : (s >> 1);
    endfunction

    assign step_a = lfsr_step(lfsr_q);
    assign step_b = lfsr_step(step_a);

    assign instr_valid = (state_q == S_WARMUP) || ((state_q == S_RUN) && word_valid_q);
    assign instr       = (state_q == S_RUN) ? word_q : NOP;
    assign busy        = (state_q == S_WARMUP) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign accept      = instr_valid & instr_ready;

    // Build the candidate word from two LFSR steps: step_a supplies the low 32 random bits, step_b the high ones.
    always_comb begin
        choice   = step_a[1:0];
        funct3   = step_a[31:29];
        imm      = step_a[13:2];
        imm_l    = step_b[12:1];
        funct3_l = {step_b[0], 2'b00};
        if (funct3 == 3'd5) begin
            imm = imm & 12'h41F;
        end else if (funct3 == 3'd1) begin
            imm = imm & 12'h01F;
        end
        if (choice[1]) begin
            new_word = {imm, step_a[18:14], funct3, step_a[28:24], 7'b0010011};
        end else if (choice[0]) begin
            new_word = {imm_l[11:5], step_a[23:19], step_a[18:14], 3'b000, imm_l[4:0], 7'b0100011};
        end else begin
            new_word = {imm_l, step_a[18:14], funct3_l, step_a[28:24], 7'b0000011};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; leaving warmup always loads the first random word in the same cycle.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        warm_exit = 1'b0;
        clear_cnt = 1'b0;
        count_acc = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clear_cnt = 1'b1;
                    if (WARMUP == 4'd0) begin
                        warm_exit = 1'b1;
                    end else begin
                        state_d = S_WARMUP;
                    end
                end
            end
            S_WARMUP: begin
                if (instr_ready && (warm_cnt_q == WARMUP - 4'd1)) begin
                    warm_exit = 1'b1;
                end
            end
            S_RUN: begin
                load = (!word_valid_q || instr_ready) && (gen_cnt_q < NUM_INSTRS);
                if (accept) begin
                    count_acc = 1'b1;
                    if (acc_cnt_q + 16'd1 == NUM_INSTRS) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (warm_exit) begin
            if (NUM_INSTRS == 16'd0) begin
                state_d = S_DONE;
            end else begin
                state_d = S_RUN;
                load    = 1'b1;
            end
        end
    end

    // Datapath: LFSR, held word, run bookkeeping and saturating per-class accept counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q       <= SEED_INIT;
            word_q       <= NOP;
            word_valid_q <= 1'b0;
            class_q      <= 2'b00;
            warm_cnt_q   <= 4'd0;
            gen_cnt_q    <= 16'd0;
            acc_cnt_q    <= 16'd0;
            cnt_alu      <= 16'd0;
            cnt_ld       <= 16'd0;
            cnt_st       <= 16'd0;
        end else begin
            if (clear_cnt) begin
                warm_cnt_q <= 4'd0;
            end else if ((state_q == S_WARMUP) && instr_ready) begin
                warm_cnt_q <= warm_cnt_q + 4'd1;
            end

            if (load) begin
                lfsr_q       <= step_b;
                word_q       <= new_word;
                class_q      <= choice;
                word_valid_q <= 1'b1;
                gen_cnt_q    <= warm_exit ? 16'd1 : gen_cnt_q + 16'd1;
            end else if (accept && (state_q == S_RUN)) begin
                word_valid_q <= 1'b0;
            end

            if (warm_exit) begin
                acc_cnt_q <= 16'd0;
            end else if (count_acc) begin
                acc_cnt_q <= acc_cnt_q + 16'd1;
            end

            if (clear_cnt) begin
                cnt_alu <= 16'd0;
                cnt_ld  <= 16'd0;
                cnt_st  <= 16'd0;
            end else if (count_acc) begin
                if (class_q[1]) begin
                    if (cnt_alu != 16'hFFFF) cnt_alu <= cnt_alu + 16'd1;
                end else if (class_q[0]) begin
                    if (cnt_st != 16'hFFFF) cnt_st <= cnt_st + 16'd1;
                end else begin
                    if (cnt_ld != 16'hFFFF) cnt_ld <= cnt_ld + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ils_instr_gen.sv
// tb_ils_instr_gen: two generator instances checked cycle by cycle against a
// transaction-level model of the warmup/random stream, plus directed literal checks.
module tb_ils_instr_gen;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] MASK = 32'h80200003;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_v [2];
    logic        ready_v [2];
    logic        valid_w [2];
    logic [31:0] instr_w [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] alu_w   [2];
    logic [15:0] ld_w    [2];
    logic [15:0] st_w    [2];

    int checks = 0;
    int errors = 0;

    // Model state per instance: phase 0 idle, 1 active, 2 done.
    logic [31:0] m_lfsr  [2];
    int          m_phase [2];
    int          m_acc   [2];
    int          m_alu   [2];
    int          m_ld    [2];
    int          m_st    [2];

    ils_instr_gen #(.SEED(32'd1019), .NUM_INSTRS(16'd4), .WARMUP(4'd2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .instr_ready(ready_v[0]),
        .instr_valid(valid_w[0]), .instr(instr_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .cnt_alu(alu_w[0]), .cnt_ld(ld_w[0]), .cnt_st(st_w[0])
    );

    ils_instr_gen #(.SEED(32'd0), .NUM_INSTRS(16'hFFFF), .WARMUP(4'd1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .instr_ready(ready_v[1]),
        .instr_valid(valid_w[1]), .instr(instr_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .cnt_alu(alu_w[1]), .cnt_ld(ld_w[1]), .cnt_st(st_w[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic int warm_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int num_of(input int d);
        return (d == 0) ? 4 : 65535;
    endfunction

    // Seed 0 is expected to behave exactly like seed 1.
    function automatic logic [31:0] seed_of(input int d);
        return (d == 0) ? 32'd1019 : 32'd1;
    endfunction

    function automatic logic [31:0] model_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? MASK : 32'd0);
    endfunction

    function automatic logic [1:0] model_choice(input logic [31:0] s);
        logic [31:0] a;
        a = model_step(s);
        return a[1:0];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] s);
        logic [63:0] r;
        logic [11:0] imm;
        logic [11:0] imm_l;
        logic [2:0]  f3;
        logic [2:0]  f3l;
        r[31:0]  = model_step(s);
        r[63:32] = model_step(r[31:0]);
        imm   = r[13:2];
        f3    = r[31:29];
        f3l   = {r[32], 2'b00};
        imm_l = r[44:33];
        if (f3 == 3'd5) imm = imm & 12'h41F;
        if (f3 == 3'd1) imm = imm & 12'h01F;
        if (r[1]) return {imm, r[18:14], f3, r[28:24], 7'b0010011};
        if (r[0]) return {imm_l[11:5], r[23:19], r[18:14], 3'b000, imm_l[4:0], 7'b0100011};
        return {imm_l, r[18:14], f3l, r[28:24], 7'b0000011};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Property checks on an accepted random word from the long-run instance.
    task automatic check_fields(input logic [31:0] w);
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'd5)
            check_output("alu_f3_5_imm", {26'd0, w[31], w[29:25]}, 32'd0);
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'd1)
            check_output("alu_f3_1_imm", {25'd0, w[31:25]}, 32'd0);
        if (w[6:0] == 7'b0000011)
            check_output("load_f3", {30'd0, w[13:12]}, 32'd0);
        if (w[6:0] == 7'b0100011)
            check_output("store_f3", {29'd0, w[14:12]}, 32'd0);
    endtask

    task automatic compare_dut(input int d);
        logic [31:0] word;
        logic [31:0] exp_instr;
        logic [1:0]  ch;
        if (!reset_n) begin
            check_output($sformatf("rst_instr%0d", d), instr_w[d], NOP);
            check_output($sformatf("rst_valid%0d", d), {31'd0, valid_w[d]}, 32'd0);
            check_output($sformatf("rst_busy%0d", d), {31'd0, busy_w[d]}, 32'd0);
            check_output($sformatf("rst_done%0d", d), {31'd0, done_w[d]}, 32'd0);
            check_output($sformatf("rst_cnts%0d", d), {alu_w[d] | ld_w[d] | st_w[d], 16'd0}, 32'd0);
            m_lfsr[d]  = seed_of(d);
            m_phase[d] = 0;
            m_acc[d]   = 0;
            m_alu[d]   = 0;
            m_ld[d]    = 0;
            m_st[d]    = 0;
            return;
        end
        word      = model_word(m_lfsr[d]);
        exp_instr = (m_phase[d] == 1 && m_acc[d] >= warm_of(d)) ? word : NOP;
        check_output($sformatf("valid%0d", d), {31'd0, valid_w[d]}, {31'd0, m_phase[d] == 1});
        check_output($sformatf("busy%0d", d), {31'd0, busy_w[d]}, {31'd0, m_phase[d] == 1});
        check_output($sformatf("done%0d", d), {31'd0, done_w[d]}, {31'd0, m_phase[d] == 2});
        check_output($sformatf("instr%0d", d), instr_w[d], exp_instr);
        check_output($sformatf("cnt_alu%0d", d), {16'd0, alu_w[d]}, 32'(m_alu[d]));
        check_output($sformatf("cnt_ld%0d", d), {16'd0, ld_w[d]}, 32'(m_ld[d]));
        check_output($sformatf("cnt_st%0d", d), {16'd0, st_w[d]}, 32'(m_st[d]));

        if (m_phase[d] == 1 && ready_v[d]) begin
            if (m_acc[d] >= warm_of(d)) begin
                if (d == 1) check_fields(instr_w[d]);
                ch = model_choice(m_lfsr[d]);
                if (ch[1]) begin
                    if (m_alu[d] < 65535) m_alu[d]++;
                end else if (ch[0]) begin
                    if (m_st[d] < 65535) m_st[d]++;
                end else begin
                    if (m_ld[d] < 65535) m_ld[d]++;
                end
                m_lfsr[d] = model_step(model_step(m_lfsr[d]));
            end
            m_acc[d]++;
            if (m_acc[d] == warm_of(d) + num_of(d)) m_phase[d] = 2;
        end else if (start_v[d] && m_phase[d] != 1) begin
            m_alu[d]   = 0;
            m_ld[d]    = 0;
            m_st[d]    = 0;
            m_acc[d]   = 0;
            m_phase[d] = (warm_of(d) + num_of(d) == 0) ? 2 : 1;
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) compare_dut(d);
    end

    task automatic apply_stimulus(input int d);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
    endtask

    // Directed sequence: reset, free run, restart from done, backpressure, mid-run reset, long constrained run.
    initial begin
        int wait_cnt;
        reset_n    = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        ready_v[0] = 1'b0;
        ready_v[1] = 1'b0;

        check_output("pin_word1", model_word(32'd1), 32'h00004013);
        check_output("pin_word2", model_word(model_step(model_step(32'd1))), 32'h003000A3);

        repeat (2) @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        reset_n    = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_rst_instr", instr_w[0], NOP);
        check_output("post_rst_valid", {31'd0, valid_w[0]}, 32'd0);

        $display("[TB] free-running run on instance a");
        ready_v[0] = 1'b1;
        apply_stimulus(0);
        check_output("a_k1_valid", {31'd0, valid_w[0]}, 32'd1);
        check_output("a_k1_nop", instr_w[0], NOP);
        @(posedge clk);
        #1;
        check_output("a_k2_nop", instr_w[0], NOP);
        @(posedge clk);
        #1;
        check_output("a_k3_valid", {31'd0, valid_w[0]}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_output("a_k7_done", {31'd0, done_w[0]}, 32'd1);
        check_output("a_k7_valid", {31'd0, valid_w[0]}, 32'd0);
        check_output("a_sum", 32'(alu_w[0]) + 32'(ld_w[0]) + 32'(st_w[0]), 32'd4);

        $display("[TB] restart from done on instance a");
        apply_stimulus(0);
        repeat (6) @(posedge clk);
        #1;
        check_output("a_rerun_done", {31'd0, done_w[0]}, 32'd1);
        check_output("a_rerun_sum", 32'(alu_w[0]) + 32'(ld_w[0]) + 32'(st_w[0]), 32'd4);

        $display("[TB] seed corner and backpressure on instance b");
        ready_v[1] = 1'b1;
        apply_stimulus(1);
        check_output("b_k1_nop", instr_w[1], NOP);
        @(posedge clk);
        #1;
        check_output("b_first_word", instr_w[1], 32'h00004013);
        @(posedge clk);
        #1;
        check_output("b_second_word", instr_w[1], 32'h003000A3);
        @(posedge clk);
        #1;
        ready_v[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ready_v[1] = 1'b1;

        wait_cnt = 0;
        while (m_acc[1] < 10 && wait_cnt < 100) begin
            @(posedge clk);
            wait_cnt++;
        end
        check_output("b_reached_10", {31'd0, m_acc[1] >= 10}, 32'd1);

        $display("[TB] asynchronous reset mid-run");
        #3;
        reset_n = 1'b0;
        #1;
        check_output("async_instr", instr_w[1], NOP);
        check_output("async_valid", {31'd0, valid_w[1]}, 32'd0);
        check_output("async_busy", {31'd0, busy_w[1]}, 32'd0);
        check_output("async_cnt_alu", {16'd0, alu_w[1]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] restart and constrained long run on instance b");
        apply_stimulus(1);
        check_output("b_restart_nop", instr_w[1], NOP);
        @(posedge clk);
        #1;
        check_output("b_restart_first", instr_w[1], 32'h00004013);
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            ready_v[1] = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        ready_v[1] = 1'b1;
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
